// File: rtl/sn_frame_update_ctrl.sv
// Per-frame sequencer for the sn analysis buffer: shifts out the oldest N_SAMP samples,
// appends N_SAMP new samples from the speech RAM, and lends the sn RAM read port to a client when idle.
module sn_frame_update_ctrl #(
  parameter int N            = 32,
  parameter int AW           = 10,
  parameter int N_SAMP       = 80,
  parameter int M_PITCH      = 320,
  parameter int RD_LAT       = 2,
  parameter int SPEECH_DEPTH = 960
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_frame,
  output logic          busy,
  output logic          done_frame,
  output logic [15:0]   frame_count,
  output logic [AW-1:0] speech_addr,
  input  logic [N-1:0]  speech_rdata,
  output logic [AW-1:0] sn_addr,
  output logic [N-1:0]  sn_wdata,
  output logic          sn_re,
  output logic          sn_we,
  input  logic [N-1:0]  sn_rdata,
  input  logic          client_req,
  input  logic [AW-1:0] client_addr,
  output logic          client_gnt,
  output logic          client_valid,
  output logic [N-1:0]  client_rdata
);

  // state   | meaning
  // IDLE    | waiting for start_frame; client owns the sn read port
  // INIT    | draining client reads still in flight
  // SH_RD   | issue sn read of sample idx+N_SAMP
  // SH_WAIT | RAM read latency, capture on last cycle
  // SH_WR   | write captured sample to sn[idx]
  // FL_RD   | issue speech read at speech_ptr+idx
  // FL_WAIT | RAM read latency, capture on last cycle
  // FL_WR   | write captured sample to sn[M_PITCH-N_SAMP+idx]
  // DONE    | pulse done_frame, advance frame_count and speech_ptr
  typedef enum logic [3:0] {
    IDLE, INIT, SH_RD, SH_WAIT, SH_WR, FL_RD, FL_WAIT, FL_WR, DONE
  } state_t;

  localparam int SH_LAST_I = M_PITCH - N_SAMP - 1;
  localparam int FL_LAST_I = N_SAMP - 1;
  localparam int FL_BASE_I = M_PITCH - N_SAMP;
  localparam int WAIT_LD_I = RD_LAT - 1;

  localparam logic [AW-1:0] SH_LAST  = SH_LAST_I[AW-1:0];
  localparam logic [AW-1:0] FL_LAST  = FL_LAST_I[AW-1:0];
  localparam logic [AW-1:0] FL_BASE  = FL_BASE_I[AW-1:0];
  localparam logic [AW-1:0] SH_OFS   = N_SAMP[AW-1:0];
  localparam logic [AW:0]   PTR_STEP = N_SAMP[AW:0];
  localparam logic [AW:0]   PTR_END  = SPEECH_DEPTH[AW:0];
  localparam logic [2:0]    WAIT_LD  = WAIT_LD_I[2:0];

  state_t            state;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     speech_ptr;
  logic [AW-1:0]     sn_addr_q;
  logic              sn_re_q;
  logic [2:0]        wait_cnt;
  logic [RD_LAT-1:0] pend;
  logic [AW:0]       ptr_sum;

  // start_frame wins over a same-cycle client request
  assign client_gnt   = rst & (state == IDLE) & client_req & ~start_frame;
  assign sn_addr      = client_gnt ? client_addr : sn_addr_q;
  assign sn_re        = client_gnt | sn_re_q;
  assign client_valid = pend[RD_LAT-1];
  assign client_rdata = sn_rdata;
  assign ptr_sum      = {1'b0, speech_ptr} + PTR_STEP;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend <= '0;
    end else begin
      pend <= (pend << 1) | RD_LAT'(client_gnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      speech_ptr  <= '0;
      wait_cnt    <= '0;
      frame_count <= '0;
      busy        <= 1'b0;
      done_frame  <= 1'b0;
      speech_addr <= '0;
      sn_addr_q   <= '0;
      sn_wdata    <= '0;
      sn_re_q     <= 1'b0;
      sn_we       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_frame) begin
            state <= INIT;
            busy  <= 1'b1;
          end
        end
        INIT: begin
          if (pend == '0) begin
            idx       <= '0;
            state     <= SH_RD;
            sn_addr_q <= SH_OFS;
            sn_re_q   <= 1'b1;
          end
        end
        SH_RD: begin
          wait_cnt <= WAIT_LD;
          state    <= SH_WAIT;
        end
        SH_WAIT: begin
          if (wait_cnt == 3'd0) begin
            sn_wdata  <= sn_rdata;
            sn_addr_q <= idx;
            sn_re_q   <= 1'b0;
            sn_we     <= 1'b1;
            state     <= SH_WR;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        SH_WR: begin
          sn_we <= 1'b0;
          if (idx == SH_LAST) begin
            idx         <= '0;
            speech_addr <= speech_ptr;
            state       <= FL_RD;
          end else begin
            idx       <= idx + 1'b1;
            sn_addr_q <= idx + SH_OFS + 1'b1;
            sn_re_q   <= 1'b1;
            state     <= SH_RD;
          end
        end
        FL_RD: begin
          wait_cnt <= WAIT_LD;
          state    <= FL_WAIT;
        end
        FL_WAIT: begin
          if (wait_cnt == 3'd0) begin
            sn_wdata  <= speech_rdata;
            sn_addr_q <= FL_BASE + idx;
            sn_we     <= 1'b1;
            state     <= FL_WR;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        FL_WR: begin
          sn_we <= 1'b0;
          if (idx == FL_LAST) begin
            done_frame <= 1'b1;
            state      <= DONE;
          end else begin
            idx         <= idx + 1'b1;
            speech_addr <= speech_ptr + idx + 1'b1;
            state       <= FL_RD;
          end
        end
        DONE: begin
          done_frame  <= 1'b0;
          busy        <= 1'b0;
          frame_count <= frame_count + 16'd1;
          speech_ptr  <= (ptr_sum >= PTR_END) ? '0 : ptr_sum[AW-1:0];
          speech_addr <= '0;
          sn_addr_q   <= '0;
          sn_wdata    <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sn_frame_update_ctrl.sv
// Directed bench for sn_frame_update_ctrl: RAM models, write/client scoreboards,
// frame latency, speech pointer wrap, client arbitration and mid-frame reset.
`timescale 1ns/1ps
module tb_sn_frame_update_ctrl;

  localparam int N      = 32;
  localparam int AW     = 10;
  localparam int LAT2   = 2 + 320 * (2 + 2);
  // RD_LAT=4 frame with a client read granted the cycle before start: INIT holds three extra cycles
  localparam int LAT4C  = 2 + 320 * (4 + 2) + 3;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        chk_spa;
    logic [9:0]  spa;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst, load_req;
  logic          start_frame, busy, done_frame;
  logic [15:0]   frame_count;
  logic [AW-1:0] speech_addr, sn_addr, client_addr;
  logic [N-1:0]  speech_rdata, sn_wdata, sn_rdata, client_rdata;
  logic          sn_re, sn_we, client_req, client_gnt, client_valid;

  logic          start4, busy4, done4, sn_re4, sn_we4, creq4, gnt4, valid4;
  logic [15:0]   fc4;
  logic [AW-1:0] spa4, sn_addr4, caddr4;
  logic [N-1:0]  sp_rdata4, sn_wdata4, sn_rdata4, crdata4;

  logic [31:0] sn_mem [0:1023];
  logic [31:0] sn_mem4[0:1023];
  logic [31:0] speech_mem[0:1023];
  logic [31:0] model[0:1023];
  logic [31:0] sn_pipe[2], sp_pipe[2], sn_pipe4[4], sp_pipe4[4];

  wr_t         wq[$];
  logic [31:0] cq[$], cq4[$];
  int cyc = 0, n_vec = 0, n_err = 0, done_cnt = 0, fc_exp = 0, eptr = 0;
  int last_valid_cyc = -100, valid4_cyc = -100, first_shrd4 = -1;
  logic [9:0] first_fill_spa, last_fill_spa;

  sn_frame_update_ctrl #(.N(N), .AW(AW), .N_SAMP(80), .M_PITCH(320), .RD_LAT(2), .SPEECH_DEPTH(960)) u_dut (
    .clk(clk), .rst(rst), .start_frame(start_frame), .busy(busy), .done_frame(done_frame),
    .frame_count(frame_count), .speech_addr(speech_addr), .speech_rdata(speech_rdata),
    .sn_addr(sn_addr), .sn_wdata(sn_wdata), .sn_re(sn_re), .sn_we(sn_we), .sn_rdata(sn_rdata),
    .client_req(client_req), .client_addr(client_addr), .client_gnt(client_gnt),
    .client_valid(client_valid), .client_rdata(client_rdata));

  sn_frame_update_ctrl #(.N(N), .AW(AW), .N_SAMP(80), .M_PITCH(320), .RD_LAT(4), .SPEECH_DEPTH(960)) u_dut4 (
    .clk(clk), .rst(rst), .start_frame(start4), .busy(busy4), .done_frame(done4),
    .frame_count(fc4), .speech_addr(spa4), .speech_rdata(sp_rdata4),
    .sn_addr(sn_addr4), .sn_wdata(sn_wdata4), .sn_re(sn_re4), .sn_we(sn_we4), .sn_rdata(sn_rdata4),
    .client_req(creq4), .client_addr(caddr4), .client_gnt(gnt4),
    .client_valid(valid4), .client_rdata(crdata4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sn_rdata     = sn_pipe[1];
  assign speech_rdata = sp_pipe[1];
  assign sn_rdata4    = sn_pipe4[3];
  assign sp_rdata4    = sp_pipe4[3];

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 1024; k++) begin
        sn_mem[k]  <= 32'(k);
        sn_mem4[k] <= 32'(k);
      end
    end else begin
      if (sn_we)  sn_mem[sn_addr]   <= sn_wdata;
      if (sn_we4) sn_mem4[sn_addr4] <= sn_wdata4;
    end
    sn_pipe[0]  <= sn_re  ? sn_mem[sn_addr]   : 32'hDEAD_BEEF;
    sn_pipe[1]  <= sn_pipe[0];
    sp_pipe[0]  <= speech_mem[speech_addr];
    sp_pipe[1]  <= sp_pipe[0];
    sn_pipe4[0] <= sn_re4 ? sn_mem4[sn_addr4] : 32'hDEAD_BEEF;
    sp_pipe4[0] <= speech_mem[spa4];
    for (int k = 1; k < 4; k++) begin
      sn_pipe4[k] <= sn_pipe4[k-1];
      sp_pipe4[k] <= sp_pipe4[k-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (load_req) for (int k = 0; k < 1024; k++) model[k] = 32'(k);
    if (sn_we) begin
      chk("wr_q_nonempty", wq.size() > 0, 1);
      chk("re_we_excl", sn_re, 0);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_addr", sn_addr, e.addr);
        chk("wr_data", sn_wdata, e.data);
        if (e.chk_spa) chk("fill_speech_addr", speech_addr, e.spa);
        if (e.addr == 10'd240) first_fill_spa = speech_addr;
        if (e.addr == 10'd319) last_fill_spa = speech_addr;
        model[e.addr] = e.data;
      end
    end
    if (client_valid) begin
      chk("cq_nonempty", cq.size() > 0, 1);
      if (cq.size() > 0) chk("client_rdata", client_rdata, cq.pop_front());
      last_valid_cyc = cyc;
    end
    if (done_frame) done_cnt++;
  end

  always @(negedge clk) begin
    if (valid4) begin
      chk("cq4_nonempty", cq4.size() > 0, 1);
      if (cq4.size() > 0) chk("client4_rdata", crdata4, cq4.pop_front());
      valid4_cyc = cyc;
    end
    if (busy4 && sn_re4 && first_shrd4 < 0) first_shrd4 = cyc;
  end

  task automatic push_frame();
    wr_t e;
    for (int k = 0; k < 240; k++) begin
      e.addr = 10'(k); e.data = model[k + 80]; e.chk_spa = 1'b0; e.spa = '0;
      wq.push_back(e);
    end
    for (int k = 0; k < 80; k++) begin
      e.addr = 10'(240 + k); e.data = 32'(1000 + eptr + k); e.chk_spa = 1'b1; e.spa = 10'(eptr + k);
      wq.push_back(e);
    end
    eptr = (eptr + 80 >= 960) ? 0 : eptr + 80;
  endtask

  task automatic run_frame(input bit with_client, input int pulse_at);
    int p, lat, dc0;
    bit got;
    push_frame();
    dc0 = done_cnt;
    start_frame = 1'b1;
    if (with_client) begin client_req = 1'b1; client_addr = 10'd242; end
    p = cyc;
    if (with_client) begin
      @(negedge clk);
      chk("gnt_vs_start", client_gnt, 0);
    end
    @(posedge clk); #1;
    start_frame = 1'b0; client_req = 1'b0;
    chk("busy_after_start", busy, 1);
    got = 1'b0; lat = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      start_frame = (pulse_at > 0 && cyc - p == pulse_at);
      if (done_frame) begin got = 1'b1; lat = cyc - p; end
    end
    start_frame = 1'b0;
    chk("done_seen", got, 1);
    if (got) chk("frame_latency", lat, LAT2);
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
    repeat (3) @(posedge clk); #1;
    chk("done_pulses", done_cnt - dc0, 1);
    fc_exp++;
    chk("frame_count", frame_count, fc_exp);
  endtask

  initial begin
    int g, p, lat;
    bit got;
    rst = 1'b0; load_req = 1'b1; start_frame = 1'b0; client_req = 1'b0; client_addr = '0;
    start4 = 1'b0; creq4 = 1'b0; caddr4 = '0;
    for (int k = 0; k < 1024; k++) speech_mem[k] = (k < 960) ? 32'(1000 + k) : 32'd0;
    repeat (3) @(posedge clk); #1;

    chk("rst_busy", busy, 0);          chk("rst_done", done_frame, 0);
    chk("rst_sn_re", sn_re, 0);        chk("rst_sn_we", sn_we, 0);
    chk("rst_gnt", client_gnt, 0);     chk("rst_valid", client_valid, 0);
    chk("rst_fc", frame_count, 0);     chk("rst_sn_addr", sn_addr, 0);
    chk("rst_speech_addr", speech_addr, 0); chk("rst_wdata", sn_wdata, 0);
    chk("rst_busy4", busy4, 0);
    load_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 0);
    for (int k = 0; k < 240; k++) chk("sn_shifted", sn_mem[k], 80 + k);
    for (int k = 0; k < 80; k++)  chk("sn_filled", sn_mem[240 + k], 1000 + k);

    for (int f = 2; f <= 13; f++) run_frame(0, 0);
    chk("wrap_first_spa", first_fill_spa, 0);
    chk("wrap_last_spa", last_fill_spa, 79);

    client_req = 1'b1; client_addr = 10'd242;
    cq.push_back(model[242]);
    g = cyc;
    @(negedge clk);
    chk("gnt_alone", client_gnt, 1);
    chk("gnt_sn_re", sn_re, 1);
    chk("gnt_sn_addr", sn_addr, 242);
    @(posedge clk); #1;
    client_req = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("client_valid_delay", last_valid_cyc - g, 2);
    chk("client_q_drained", cq.size(), 0);

    run_frame(1, 0);

    creq4 = 1'b1; caddr4 = 10'd242;
    cq4.push_back(32'd242);
    g = cyc;
    @(negedge clk);
    chk("gnt4", gnt4, 1);
    @(posedge clk); #1;
    creq4 = 1'b0; start4 = 1'b1; p = cyc;
    @(posedge clk); #1;
    start4 = 1'b0;
    got = 1'b0; lat = 0;
    for (int k = 0; k < 4000 && !got; k++) begin
      @(negedge clk);
      if (done4) begin got = 1'b1; lat = cyc - p; end
    end
    chk("done4_seen", got, 1);
    chk("valid4_delay", valid4_cyc - g, 4);
    chk("init_hold4", first_shrd4 - valid4_cyc, 2);
    if (got) chk("latency4", lat, LAT4C);
    repeat (2) @(posedge clk); #1;
    chk("fc4", fc4, 1);
    for (int k = 0; k < 240; k++) chk("sn4_shifted", sn_mem4[k], 80 + k);
    for (int k = 0; k < 80; k++)  chk("sn4_filled", sn_mem4[240 + k], 1000 + k);

    run_frame(0, 500);

    push_frame();
    start_frame = 1'b1; p = cyc;
    @(posedge clk); #1;
    start_frame = 1'b0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (cyc - p == 700) break;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sn_we", sn_we, 0);
    chk("midrst_fc", frame_count, 0);
    chk("midrst_done", done_frame, 0);
    rst = 1'b1;
    wq.delete();
    eptr = 0; fc_exp = 0;
    @(posedge clk); #1;
    run_frame(0, 0);
    for (int k = 0; k < 320; k++) chk("sn_after_reset", sn_mem[k], model[k]);
    chk("wr_q_drained", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
